// File: rtl/reg_access_pkg.sv
// Shared definitions for the register-bank access arbiter: FSM encoding and data-width default.
package reg_access_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   localparam int DW_DEFAULT = 32;

endpackage

// File: rtl/reg_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i, wrapping at NREQ.
module rr_picker #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   rr_ptr_i,
   output logic [IW-1:0]   winner_o,
   output logic            valid_o
);

   int idx;

   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         // rr_ptr_i is always below NREQ, so a single subtraction wraps correctly.
         idx = int'(rr_ptr_i) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!valid_o && req_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting one register read or write per grant, sequencing LE/OE strobes on a shared bank.
module reg_access_arbiter
   import reg_access_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int NREG = 4,
   parameter int AW   = 2,
   parameter int DW   = DW_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      we,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [DW-1:0]        rdata,
   output logic                 err,
   output logic                 busy,
   output logic [NREG-1:0]      le,
   output logic [NREG-1:0]      oe,
   output logic [DW-1:0]        bus_data,
   input  logic [DW-1:0]        rd_bus,
   output logic [1:0]           dbg_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e            state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]     win_q, win_d;
   logic              we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [NREG-1:0]   le_q, le_d;
   logic [NREG-1:0]   oe_q, oe_d;
   logic [DW-1:0]     bus_q, bus_d;

   logic [IW-1:0]     pick_idx;
   logic              pick_valid;
   logic              sel_we;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic              sel_oor;
   logic              addr_oor;

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .winner_o (pick_idx),
      .valid_o  (pick_valid)
   );

   assign sel_we    = we[pick_idx];
   assign sel_addr  = addr[int'(pick_idx)*AW +: AW];
   assign sel_wdata = wdata[int'(pick_idx)*DW +: DW];
   assign sel_oor   = 32'(sel_addr) >= 32'(NREG);
   assign addr_oor  = 32'(addr_q) >= 32'(NREG);

   // Outputs are registered from the next state, so each strobe is visible in the cycle its state is occupied.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      rdata_d  = rdata_q;
      err_d    = 1'b0;
      le_d     = '0;
      oe_d     = '0;
      bus_d    = bus_q;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               win_d   = pick_idx;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               gnt_d   = NREQ'(1) << pick_idx;
               state_d = S_ACCESS;
               if (!sel_oor) begin
                  if (sel_we) begin
                     le_d  = NREG'(1) << sel_addr;
                     bus_d = sel_wdata;
                  end else begin
                     oe_d = NREG'(1) << sel_addr;
                  end
               end
            end
         end
         S_ACCESS: begin
            if (!we_q && !addr_oor) begin
               oe_d    = oe_q;
               state_d = S_CAPTURE;
            end else begin
               done_d  = gnt_q;
               err_d   = addr_oor;
               state_d = S_DONE;
               if (!we_q) rdata_d = '0;
            end
         end
         S_CAPTURE: begin
            rdata_d = rd_bus;
            done_d  = gnt_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            gnt_d    = '0;
            rr_ptr_d = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         le_q     <= '0;
         oe_q     <= '0;
         bus_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         le_q     <= le_d;
         oe_q     <= oe_d;
         bus_q    <= bus_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign le        = le_q;
   assign oe        = oe_q;
   assign bus_data  = bus_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter (2 requesters, 3 registers) with a queue-based done scoreboard.
module tb_reg_access_arbiter;

   // Handshake: a requester raises req with we/addr/wdata and holds it until its done pulse;
   // the arbiter answers with gnt (ACCESS..DONE) and a one-cycle done, rdata/err valid with done.

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req, we;
   logic [3:0]  addr;
   logic [63:0] wdata;
   logic [1:0]  gnt, done;
   logic [31:0] rdata;
   logic        err, busy;
   logic [2:0]  le, oe;
   logic [31:0] bus_data, rd_bus;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   reg_access_arbiter #(.NREQ(2), .NREG(3), .AW(2), .DW(32)) dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .done(done), .rdata(rdata), .err(err), .busy(busy),
      .le(le), .oe(oe), .bus_data(bus_data), .rd_bus(rd_bus), .dbg_state(dbg_state)
   );

   // Clock/reset block
   always #5 clock = ~clock;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   // Register bank model: data appears on rd_bus the cycle after oe rises.
   logic [31:0] regs [3];
   always @(posedge clock) begin
      if (reset) begin
         regs[0] <= 32'h1111_1111;
         regs[1] <= 32'hAEA7_AEA7;
         regs[2] <= 32'h0;
         rd_bus  <= 32'h0;
      end else begin
         rd_bus <= 32'h0;
         for (int i = 0; i < 3; i++) begin
            if (oe[i]) rd_bus <= regs[i];
            if (le[i]) regs[i] <= bus_data;
         end
      end
   end

   // Scoreboard
   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rdata;
      logic [2:0]  le;
      logic [2:0]  oe;
      int          lat;
      logic [31:0] bus;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, expv);
      end
   endtask

   task automatic push_exp(input int idx, input logic e, input logic [31:0] rd, input logic [2:0] l,
                           input logic [2:0] o, input int lat, input logic [31:0] bus);
      exp_t x;
      x.idx = idx; x.err = e; x.rdata = rd; x.le = l; x.oe = o; x.lat = lat; x.bus = bus;
      exp_q.push_back(x);
   endtask

   // Monitor: samples on the falling edge, pops one expectation per done pulse.
   int          cyc = 0;
   int          g_start = 0;
   logic [1:0]  prev_gnt = 2'b0;
   logic [2:0]  le_acc = 3'b0, oe_acc = 3'b0;
   int          le_cnt = 0, oe_cnt = 0;
   logic [31:0] bus_at_le = 32'h0;
   logic        bad_strobe = 1'b0;
   logic        after_done = 1'b0;
   exp_t        e;

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            prev_gnt = 2'b0; le_acc = 3'b0; oe_acc = 3'b0; le_cnt = 0; oe_cnt = 0;
            bad_strobe = 1'b0; after_done = 1'b0;
         end else begin
            if (after_done) begin
               check("gnt_release", 32'(gnt), 32'h0);
               check("busy_idle", 32'(busy), 32'h0);
               after_done = 1'b0;
            end
            if (gnt != 2'b0 && prev_gnt == 2'b0) g_start = cyc;
            prev_gnt = gnt;
            le_acc |= le;
            oe_acc |= oe;
            if (le != 3'b0) begin le_cnt++; bus_at_le = bus_data; end
            if (oe != 3'b0) oe_cnt++;
            if ((le != 3'b0 && oe != 3'b0) || $countones(le) > 1 || $countones(oe) > 1) bad_strobe = 1'b1;
            if (err && done == 2'b0) check("err_without_done", 32'(err), 32'h0);
            if (done != 2'b0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'(done), 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_onehot", 32'(done), 32'(1) << e.idx);
                  check("gnt_at_done", 32'(gnt), 32'(1) << e.idx);
                  check("err", 32'(err), 32'(e.err));
                  check("rdata", rdata, e.rdata);
                  check("latency", 32'(cyc - g_start), 32'(e.lat));
                  check("le_pattern", 32'(le_acc), 32'(e.le));
                  check("le_cycles", 32'(le_cnt), (e.le != 3'b0) ? 32'd1 : 32'd0);
                  check("oe_pattern", 32'(oe_acc), 32'(e.oe));
                  check("oe_cycles", 32'(oe_cnt), (e.oe != 3'b0) ? 32'd2 : 32'd0);
                  if (e.le != 3'b0) check("bus_at_le", bus_at_le, e.bus);
                  check("bus_hold", bus_data, e.bus);
                  check("strobe_exclusive", 32'(bad_strobe), 32'h0);
                  check("busy_active", 32'(busy), 32'h1);
               end
               le_acc = 3'b0; oe_acc = 3'b0; le_cnt = 0; oe_cnt = 0;
               bad_strobe = 1'b0; after_done = 1'b1;
            end
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input int i);
      int n;
      n = 0;
      tick();
      while (!done[i] && n < 40) begin
         tick();
         n++;
      end
      if (!done[i]) check($sformatf("done_timeout_req%0d", i), 32'(done[i]), 32'h1);
   endtask

   task automatic access(input int i, input logic w, input logic [1:0] a, input logic [31:0] d);
      we[i] = w;
      addr[i*2 +: 2] = a;
      wdata[i*32 +: 32] = d;
      req[i] = 1'b1;
      wait_done(i);
      req[i] = 1'b0;
      tick();
   endtask

   task automatic hold_writes(input int i, input logic [1:0] a0, input logic [31:0] d0,
                              input logic [1:0] a1, input logic [31:0] d1);
      we[i] = 1'b1;
      addr[i*2 +: 2] = a0;
      wdata[i*32 +: 32] = d0;
      req[i] = 1'b1;
      wait_done(i);
      addr[i*2 +: 2] = a1;
      wdata[i*32 +: 32] = d1;
      wait_done(i);
      req[i] = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1; req = 2'b0; we = 2'b0; addr = 4'h0; wdata = 64'h0;
      tick(); tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_le", 32'(le), 32'h0);
      check("rst_oe", 32'(oe), 32'h0);
      check("rst_bus", bus_data, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      reset = 1'b0;
      tick();

      // Single write, single read, read-back of the written register.
      push_exp(0, 1'b0, 32'h0, 3'b100, 3'b000, 1, 32'hACA6_ACA6);
      access(0, 1'b1, 2'd2, 32'hACA6_ACA6);
      push_exp(1, 1'b0, 32'hAEA7_AEA7, 3'b000, 3'b010, 2, 32'hACA6_ACA6);
      access(1, 1'b0, 2'd1, 32'h0);
      push_exp(0, 1'b0, 32'hACA6_ACA6, 3'b000, 3'b100, 2, 32'hACA6_ACA6);
      access(0, 1'b0, 2'd2, 32'h0);

      // Reset in CAPTURE: the read is dropped and all outputs clear.
      we[1] = 1'b0; addr[3:2] = 2'd1; req[1] = 1'b1;
      n = 0;
      tick();
      while (oe == 3'b0 && n < 20) begin tick(); n++; end
      check("oe_before_reset", 32'(oe), 32'h2);
      tick();
      check("state_capture", 32'(dbg_state), 32'h2);
      reset = 1'b1; req = 2'b0;
      tick();
      check("mid_rst_oe", 32'(oe), 32'h0);
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_done", 32'(done), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);

      // Contention held from reset: grant order 0,1,0,1 (rr_ptr restarts at 0).
      push_exp(0, 1'b0, 32'h0, 3'b001, 3'b000, 1, 32'h0000_0A00);
      push_exp(1, 1'b0, 32'h0, 3'b100, 3'b000, 1, 32'h0000_0B02);
      push_exp(0, 1'b0, 32'h0, 3'b010, 3'b000, 1, 32'h0000_0A01);
      push_exp(1, 1'b0, 32'h0, 3'b001, 3'b000, 1, 32'h0000_0B03);
      fork
         hold_writes(0, 2'd0, 32'h0000_0A00, 2'd1, 32'h0000_0A01);
         hold_writes(1, 2'd2, 32'h0000_0B02, 2'd0, 32'h0000_0B03);
         begin tick(); reset = 1'b0; end
      join
      tick();

      push_exp(1, 1'b0, 32'h0000_0B03, 3'b000, 3'b001, 2, 32'h0000_0B03);
      access(1, 1'b0, 2'd0, 32'h0);
      push_exp(0, 1'b0, 32'h0000_0A01, 3'b000, 3'b010, 2, 32'h0000_0B03);
      access(0, 1'b0, 2'd1, 32'h0);

      // Late change of wdata/addr/we during ACCESS is ignored.
      push_exp(0, 1'b0, 32'h0000_0A01, 3'b010, 3'b000, 1, 32'hACA6_ACA6);
      we[0] = 1'b1; addr[1:0] = 2'd1; wdata[31:0] = 32'hACA6_ACA6; req[0] = 1'b1;
      n = 0;
      tick();
      while (gnt[0] == 1'b0 && n < 20) begin tick(); n++; end
      wdata[31:0] = 32'hEEA6_EEA6; addr[1:0] = 2'd0; we[0] = 1'b0;
      wait_done(0);
      req[0] = 1'b0;
      tick();
      push_exp(1, 1'b0, 32'hACA6_ACA6, 3'b000, 3'b010, 2, 32'hACA6_ACA6);
      access(1, 1'b0, 2'd1, 32'h0);

      // Out-of-range read and write: no strobes, err with done, read returns 0.
      push_exp(1, 1'b1, 32'h0, 3'b000, 3'b000, 1, 32'hACA6_ACA6);
      access(1, 1'b0, 2'd3, 32'h0);
      push_exp(0, 1'b1, 32'h0, 3'b000, 3'b000, 1, 32'hACA6_ACA6);
      access(0, 1'b1, 2'd3, 32'hDEAD_BEEF);

      // Simultaneous reads with rr_ptr=1: requester 1 wins first.
      push_exp(1, 1'b0, 32'h0000_0B03, 3'b000, 3'b001, 2, 32'hACA6_ACA6);
      push_exp(0, 1'b0, 32'h0000_0B02, 3'b000, 3'b100, 2, 32'hACA6_ACA6);
      fork
         access(0, 1'b0, 2'd2, 32'h0);
         access(1, 1'b0, 2'd0, 32'h0);
      join

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      tick(); tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
